// File: rtl/debounce_multi.sv
// debounce_multi
// Multi-channel pushbutton conditioner. Each channel passes its raw pin
// through a 2-FF synchroniser and then a four-state debounce FSM. The FSM
// only advances on clocks where tick_en is high. A press or release is
// accepted after STABLE_CNT consecutive tick samples at the new level.
// While the button is held, optional auto-repeat pulses are produced.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   tick_en       one-clock sample strobe; FSMs and counters advance only on it
//   btn_in        raw asynchronous buttons, active-high, one bit per channel
//   btn_level     debounced level, registered
//   press_pulse   one-clock pulse when a press is accepted
//   release_pulse one-clock pulse when a release is accepted
//   repeat_pulse  one-clock pulse per auto-repeat interval while held
//
// Handshake: there is no valid/ready traffic. Every pulse output is high for
// exactly one clock, the clock after the deciding tick edge.
module debounce_multi #(
    parameter int N_CH       = 5,
    parameter int CNT_W      = 14,
    parameter int STABLE_CNT = 2000,
    parameter int REPEAT_DLY = 8000,
    parameter int REPEAT_PER = 2000,
    parameter int REPEAT_EN  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_en,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        HELD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(REPEAT_PER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [N_CH-1:0]  sync_a;
    logic [N_CH-1:0]  sync_b;
    state_t           state [N_CH];
    logic [CNT_W-1:0] cnt   [N_CH];
    logic [CNT_W-1:0] rcnt  [N_CH];
    logic [N_CH-1:0]  first;

    // Synchroniser runs every clock, independent of tick_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                rcnt[i]  <= '0;
            end
            first         <= '0;
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
        end else begin
            // Pulses default low every clock so a slow tick cannot stretch them.
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            if (tick_en) begin
                for (int i = 0; i < N_CH; i++) begin
                    case (state[i])
                        IDLE: begin
                            if (sync_b[i]) begin
                                state[i] <= WAIT_PRESS;
                                cnt[i]   <= CNT_ONE;
                            end else begin
                                cnt[i]   <= '0;
                            end
                        end
                        WAIT_PRESS: begin
                            if (!sync_b[i]) begin
                                state[i] <= IDLE;
                                cnt[i]   <= '0;
                            end else if (cnt[i] == STABLE_LAST) begin
                                state[i]       <= HELD;
                                press_pulse[i] <= 1'b1;
                                btn_level[i]   <= 1'b1;
                                rcnt[i]        <= '0;
                                first[i]       <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                        HELD: begin
                            if (!sync_b[i]) begin
                                // rcnt and first are frozen so a rejected release
                                // bounce resumes the repeat schedule.
                                state[i] <= WAIT_RELEASE;
                                cnt[i]   <= CNT_ONE;
                            end else if (REPEAT_EN != 0) begin
                                if (rcnt[i] == (first[i] ? DLY_LAST : PER_LAST)) begin
                                    repeat_pulse[i] <= 1'b1;
                                    rcnt[i]         <= '0;
                                    first[i]        <= 1'b0;
                                end else begin
                                    rcnt[i] <= rcnt[i] + CNT_ONE;
                                end
                            end
                        end
                        WAIT_RELEASE: begin
                            if (sync_b[i]) begin
                                state[i] <= HELD;
                                cnt[i]   <= '0;
                            end else if (cnt[i] == STABLE_LAST) begin
                                state[i]         <= IDLE;
                                release_pulse[i] <= 1'b1;
                                btn_level[i]     <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel, parametrised button conditioner for the Basys3 pushbuttons. It is the next generation of the team's single-button debouncer.
- Per channel: a 2-FF synchroniser, then a debounce FSM with sampling paced by a shared tick strobe. Outputs are a clean level plus one-clock press, release and auto-repeat pulses.
- Sits between the board pins and the chess UI/cursor controller. Auto-repeat lets a held direction button step the cursor.

Parameters:
- N_CH, 5, number of independent button channels.
- CNT_W, 14, width of each per-channel counter. Must hold max(STABLE_CNT, REPEAT_DLY, REPEAT_PER).
- STABLE_CNT, 2000, consecutive tick samples at the new level required to accept a press or release. Must be >= 2.
- REPEAT_DLY, 8000, HELD ticks from the accepted press to the first repeat pulse. Must be >= 1.
- REPEAT_PER, 2000, HELD ticks between subsequent repeat pulses. Must be >= 1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means repeat_pulse is tied to 0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high. Reset rst, synchronous, active-high; clock clk.
- tick_en  in  1  one-clk sample strobe (e.g. ~24.4 kHz); FSMs and counters advance only when tick_en=1
- btn_in  in  N_CH  raw asynchronous buttons, active-high
- btn_level  out  N_CH  debounced level, registered
- press_pulse  out  N_CH  one-clk pulse on accepted press
- release_pulse  out  N_CH  one-clk pulse on accepted release
- repeat_pulse  out  N_CH  one-clk pulse per auto-repeat while held

Behaviour:
- Reset: the following are all 0, every channel in IDLE:
  - sync FFs, cnt, rcnt, first flag
  - btn_level, press_pulse, release_pulse, repeat_pulse
- Synchroniser: 2 FFs on every clk, not gated by tick_en. sync_i is the second FF.
- FSM actions: evaluated only on clk edges where tick_en=1. On non-tick cycles, state, cnt and rcnt hold.
- Pulse width: every pulse output is high for exactly one clk, the cycle after the deciding tick edge, then 0. No pulse can be stretched by tick_en.
- Per-channel states: IDLE, WAIT_PRESS, HELD, WAIT_RELEASE.
  - IDLE: sync=1 -> WAIT_PRESS, cnt<=1. Otherwise stay, cnt<=0.
  - WAIT_PRESS:
    - sync=0 -> IDLE, cnt<=0 (bounce rejected; no pulse).
    - sync=1 and cnt==STABLE_CNT-1 -> HELD: press_pulse<=1, btn_level<=1, rcnt<=0, first<=1.
    - Else cnt++.
  - HELD:
    - sync=0 -> WAIT_RELEASE, cnt<=1. rcnt and first frozen.
    - Else, if REPEAT_EN, limit=first?REPEAT_DLY:REPEAT_PER. rcnt==limit-1 -> repeat_pulse<=1, rcnt<=0, first<=0. Else rcnt++.
  - WAIT_RELEASE:
    - sync=1 -> HELD, cnt<=0. Release bounce rejected; rcnt/first resume, not restarted; no second press_pulse.
    - sync=0 and cnt==STABLE_CNT-1 -> IDLE: release_pulse<=1, btn_level<=0.
    - Else cnt++.
- Latency: press accepted on the STABLE_CNT-th consecutive high tick sample. press_pulse appears 1 clk after that edge, plus 2 clk synchroniser delay from the pin.
- First repeat: on the REPEAT_DLY-th HELD tick after the press tick; then every REPEAT_PER HELD ticks.
- btn_level stays 1 through WAIT_RELEASE until the release is accepted.
- Channels are fully independent. Simultaneous events on several channels give simultaneous pulses in their own bits.
- Reset mid-operation: immediate return to IDLE, no release_pulse. A button still held after reset yields a fresh press_pulse after STABLE_CNT ticks.
- Counters never wrap. Compares are exact, and the parameter constraints guarantee the limit is reached before overflow.

Test Plan:
Config for all scenarios: N_CH=2, STABLE_CNT=4, REPEAT_DLY=6, REPEAT_PER=3, tick_en=1 every clk unless stated.
1. Clean press: btn_in[0] 0->1 held 20 clk -> press_pulse[0] is a single 1-clk pulse 6 clk after the edge (2 sync + 4 samples), btn_level[0]=1 from then. Channel 1 stays all-0.
2. Bounce reject: btn_in[0] high 3 clk, low 1, high 3, low -> no pulses, btn_level[0]=0 throughout.
3. Auto-repeat: hold btn_in[1] 30 clk -> press at sample 4, repeat_pulse[1] at samples 10, 13, 16, 19, …. With REPEAT_EN=0 -> no repeat pulses.
4. Release with bounce: after press, drop 2 clk, raise 1, drop steady -> no release on the glitch; release_pulse once 4 samples into the steady low; btn_level falls with it; no extra press_pulse.
5. Tick gating: tick_en every 4th clk, btn held -> press_pulse after 4 ticks (~16 clk), still exactly 1 clk wide.
6. Reset mid-hold: assert rst for 1 clk while in HELD with the button still high -> all outputs 0 immediately, no release_pulse; new press_pulse 4 samples after rst deasserts. Both channels pressed on the same clk -> press_pulse=2'b11 on the same cycle.
